// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction buffer: a small circular FIFO of {instr, pc, pc+4}
// triples. It back-pressures fetch when full and empties on a taken branch from execute.
module if_id_buffer #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DEPTH         = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      instr_f,
    input  logic [ADDRESS_WIDTH-1:0]   pc_f,
    input  logic [ADDRESS_WIDTH-1:0]   pc_plus4_f,
    input  logic                       fetch_valid,
    output logic                       stall_f,
    input  logic                       flush_e,
    input  logic                       stall_d,
    output logic                       valid_d,
    output logic [DATA_WIDTH-1:0]      instr_d,
    output logic [ADDRESS_WIDTH-1:0]   pc_d,
    output logic [ADDRESS_WIDTH-1:0]   pc_plus4_d,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Handshake: a triple moves into the buffer when fetch_valid is high and stall_f
    // is low at a rising edge; the head moves to decode when valid_d is high and
    // stall_d is low at a rising edge. flush_e overrides both transfers.
    logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc4_mem   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Full blocks push even when the head is leaving this cycle: no pass-through.
    assign push  = fetch_valid & ~full & ~flush_e;
    assign pop   = ~empty & ~stall_d & ~flush_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_e) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage holds no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= instr_f;
            pc_mem[wr_ptr]    <= pc_f;
            pc4_mem[wr_ptr]   <= pc_plus4_f;
        end
    end

    always_comb begin
        stall_f    = full;
        valid_d    = ~empty;
        instr_d    = NOP_INSTR;
        pc_d       = '0;
        pc_plus4_d = '0;
        if (!empty) begin
            instr_d    = instr_mem[rd_ptr];
            pc_d       = pc_mem[rd_ptr];
            pc_plus4_d = pc4_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue model of the buffer contents.
module tb_if_id_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] NOP = 32'h00000013;

    logic          clk;
    logic          rst;
    logic [DW-1:0] instr_f;
    logic [AW-1:0] pc_f;
    logic [AW-1:0] pc_plus4_f;
    logic          fetch_valid;
    logic          stall_f;
    logic          flush_e;
    logic          stall_d;
    logic          valid_d;
    logic [DW-1:0] instr_d;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] pc_plus4_d;
    logic [CW-1:0] count;

    if_id_buffer #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
        .fetch_valid(fetch_valid), .stall_f(stall_f), .flush_e(flush_e), .stall_d(stall_d),
        .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: model contents {instr, pc, pc4}, oldest first, plus drained PCs
    logic [DW+2*AW-1:0] exp_q[$];
    logic [AW-1:0]      popped_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [DW+2*AW-1:0] h;
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("valid_d", 64'(valid_d), 64'd1);
            chk("instr_d", 64'(instr_d), 64'(h[DW+2*AW-1 -: DW]));
            chk("pc_d", 64'(pc_d), 64'(h[2*AW-1 -: AW]));
            chk("pc_plus4_d", 64'(pc_plus4_d), 64'(h[AW-1:0]));
        end else begin
            chk("valid_d_empty", 64'(valid_d), 64'd0);
            chk("instr_d_empty", 64'(instr_d), 64'(NOP));
            chk("pc_d_empty", 64'(pc_d), 64'd0);
            chk("pc_plus4_d_empty", 64'(pc_plus4_d), 64'd0);
        end
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("stall_f", 64'(stall_f), 64'(exp_q.size() == DEPTH));
    endtask

    // driver: one clock of stimulus; acc reports whether the model accepted the triple
    task automatic step(input logic fv, input logic [DW-1:0] ins, input logic [AW-1:0] pc,
                        input logic sd, input logic fl, output logic acc);
        logic m_push, m_pop;
        fetch_valid = fv;
        instr_f     = ins;
        pc_f        = pc;
        pc_plus4_f  = pc + 32'd4;
        stall_d     = sd;
        flush_e     = fl;
        m_push = fv && (exp_q.size() != DEPTH) && !fl;
        m_pop  = (exp_q.size() != 0) && !sd && !fl;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (m_pop) popped_q.push_back(exp_q.pop_front() >> AW);
            if (m_push) exp_q.push_back({ins, pc, pc + 32'd4});
        end
        acc = m_push;
        #1;
        check_outputs();
    endtask

    task automatic drain();
        logic a;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step(1'b0, '0, '0, 1'b0, 1'b0, a);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic a;
        int next_pc;
        int cyc;
        rst = 1'b0;
        fetch_valid = 0; instr_f = '0; pc_f = '0; pc_plus4_f = '0; stall_d = 0; flush_e = 0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // reset mid-operation
        step(1, 32'hB0, 32'h10, 1, 0, a);
        step(1, 32'hB1, 32'h14, 1, 0, a);
        chk("pre_reset_count", 64'(count), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_valid_d", 64'(valid_d), 64'd0);
        chk("rst_instr_d", 64'(instr_d), 64'h13);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_stall_f", 64'(stall_f), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;

        // streaming
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hA0 + i, 32'(4 * i), 0, 0, a);
            chk("stream_pc", 64'(pc_d), 64'(4 * i));
            chk("stream_count", 64'(count), 64'd1);
        end
        drain();

        // back-pressure
        popped_q.delete();
        step(1, 32'hC0, 32'h100, 1, 0, a);
        step(1, 32'hC1, 32'h104, 1, 0, a);
        chk("bp_count", 64'(count), 64'd2);
        chk("bp_stall_f", 64'(stall_f), 64'd1);
        step(1, 32'hC2, 32'h108, 1, 0, a);
        chk("bp_third_rejected", 64'(a), 64'd0);
        step(1, 32'hC2, 32'h108, 0, 0, a);
        chk("bp_full_pop_rejected", 64'(a), 64'd0);
        step(1, 32'hC2, 32'h108, 0, 0, a);
        chk("bp_third_accepted", 64'(a), 64'd1);
        drain();
        chk("bp_drained", 64'(popped_q.size()), 64'd3);
        if (popped_q.size() == 3) begin
            chk("bp_order0", 64'(popped_q[0]), 64'h100);
            chk("bp_order1", 64'(popped_q[1]), 64'h104);
            chk("bp_order2", 64'(popped_q[2]), 64'h108);
        end

        // wrap-around with alternating decode stall
        popped_q.delete();
        next_pc = 0;
        cyc = 0;
        while ((next_pc <= 36 || exp_q.size() != 0) && cyc < 100) begin
            step(next_pc <= 36, 32'hD0 + next_pc, 32'(next_pc), cyc[0], 0, a);
            if (a) next_pc += 4;
            cyc++;
        end
        chk("wrap_drained", 64'(popped_q.size()), 64'd10);
        for (int i = 0; i < popped_q.size() && i < 10; i++) chk("wrap_pc", 64'(popped_q[i]), 64'(4 * i));

        // flush with simultaneous push and pop
        step(1, 32'hE0, 32'h1F0, 1, 0, a);
        step(1, 32'hE1, 32'h1F4, 1, 0, a);
        step(1, 32'hE2, 32'h200, 0, 1, a);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid_d", 64'(valid_d), 64'd0);
        step(1, 32'hE3, 32'h300, 1, 0, a);
        chk("flush_next_count", 64'(count), 64'd1);
        chk("flush_next_pc", 64'(pc_d), 64'h300);
        drain();

        // full with simultaneous pop
        step(1, 32'hF0, 32'h3F0, 1, 0, a);
        step(1, 32'hF1, 32'h3F4, 1, 0, a);
        step(1, 32'hF2, 32'h400, 0, 0, a);
        chk("full_pop_count", 64'(count), 64'd1);
        chk("full_pop_rejected", 64'(a), 64'd0);
        step(1, 32'hF2, 32'h400, 0, 0, a);
        chk("full_pop_accepted", 64'(a), 64'd1);
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0), a);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Instruction buffer between the fetch stage and decode. Captures each fetched {instr, pc, pc+4} triple into a small circular FIFO so fetch can keep running while decode is stalled, and drains entries to decode in order. Issues the fetch hold signal when full, and discards all buffered instructions on a taken branch/jump resolved in execute.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDRESS_WIDTH, 32, PC width
- DEPTH, 2, entry count; power of two, >= 2
- NOP_INSTR, 32'h00000013, value driven on instr_d when empty (addi x0,x0,0)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- instr_f  input  DATA_WIDTH  fetched instruction
- pc_f  input  ADDRESS_WIDTH  PC of instr_f
- pc_plus4_f  input  ADDRESS_WIDTH  pc_f + 4
- fetch_valid  input  1  fetch presents a valid triple this cycle
- stall_f  output  1  hold to fetch `en`; 1 = fetch must not advance PC
- flush_e  input  1  taken control transfer from execute (pc_src_e)
- stall_d  input  1  decode hold; 1 = decode does not consume this cycle
- valid_d  output  1  head entry valid
- instr_d  output  DATA_WIDTH  head instruction, NOP_INSTR when empty
- pc_d  output  ADDRESS_WIDTH  head PC, 0 when empty
- pc_plus4_d  output  ADDRESS_WIDTH  head PC+4, 0 when empty
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH entries of {instr, pc, pc_plus4}; wr_ptr, rd_ptr each $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0; count tracks occupancy 0..DEPTH.
- push = fetch_valid & (count != DEPTH) & !flush_e. Writes entry at wr_ptr, wr_ptr++.
- pop = (count != 0) & !stall_d & !flush_e. rd_ptr++.
- count next = count + push - pop; simultaneous push and pop leaves count unchanged.
- stall_f = (count == DEPTH). Full blocks push even if a pop occurs that cycle (no same-cycle pass-through; one bubble of back-pressure accepted).
- Heads: valid_d = (count != 0); instr_d/pc_d/pc_plus4_d = entry[rd_ptr] when valid_d, else NOP_INSTR/0/0. Combinational from registered state only.
- Flush: flush_e=1 sets count=0, rd_ptr=wr_ptr=0 at next edge; same-cycle push and pop both suppressed. Entry contents need not be cleared.
- Reset (rst low, any time, asynchronous): count=0, pointers=0. Outputs immediately: valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, stall_f=0. Entry storage need not be reset.
- Order guarantee: entries leave in exactly the order accepted; no duplication, no loss except on flush.

## Timing
- Write-to-read latency: 1 cycle (triple accepted at edge N visible on *_d after edge N).
- stall_f, valid_d change only after a clock edge or on rst assertion.
- flush_e has priority over push, pop and stall_d.
- Reset deassertion: first push can occur at the first rising edge with rst high.
- Throughput: 1 instruction/cycle sustained when stall_d=0.

## Test plan
- Reset mid-operation: fill with 2 entries, assert rst low between edges -> valid_d=0, instr_d=32'h00000013, count=0, stall_f=0 immediately, without a clock edge.
- Streaming: pc_f=0,4,8,12 with instr 0xA0..0xA3, fetch_valid=1, stall_d=0 -> *_d shows pc 0,4,8,12 one cycle later each, count stays 1, stall_f never 1.
- Back-pressure: stall_d=1, push pc 0x100,0x104 -> count=2, stall_f=1; third triple (0x108) not accepted; release stall_d -> 0x100 then 0x104 drained, 0x108 accepted after stall_f falls, order preserved.
- Wrap-around: 10 pushes/pops with DEPTH=2 alternating stall_d -> pointers wrap, output PC sequence exactly 0,4,...,36.
- Flush with push and pop: count=2, flush_e=1, fetch_valid=1 with pc 0x200, stall_d=0 -> next cycle count=0, valid_d=0; 0x200 not present; next push 0x300 appears alone.
- Full with simultaneous pop: count=2, stall_d=0, fetch_valid=1 -> count=1 after edge, new triple not accepted that cycle, accepted the following cycle.
